// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode sequencer with SC timing; optional INTERRUPT_EN adds interrupt cycle
module fetch_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int SC_W   = 4,
    parameter int T_W    = 2 ** SC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ar_ld_pc,
    output logic              pc_inr,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic              ind_bit,
    output logic [ADDR_W-1:0] addr,
    output logic [T_W-1:0]    t,
    input  logic              sc_clr,
    input  logic              hlt,
`ifdef INTERRUPT_EN
    input  logic              ien,
    input  logic              irq,
    output logic              int_cycle,
`endif
    output logic              sc_ovf
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] F0   = 3'd1;
    localparam logic [2:0] F1   = 3'd2;
    localparam logic [2:0] DEC  = 3'd3;
    localparam logic [2:0] EXEC = 3'd4;
    localparam logic [2:0] HALT = 3'd5;
`ifdef INTERRUPT_EN
    localparam logic [2:0] INTR = 3'd6;
`endif

    localparam logic [SC_W-1:0] SC_MAX = {SC_W{1'b1}};

    logic [2:0]      state, state_nxt;
    logic [SC_W-1:0] sc, sc_nxt;
    logic            run_q;
    logic            ar_nxt, req_nxt, inr_nxt, ovf_nxt, ir_ld;
`ifdef INTERRUPT_EN
    logic            int_nxt;
`endif

    // Timing and IR fields are pure decodes of registered state.
    assign t       = (state == IDLE || state == HALT) ? '0 : (T_W'(1) << sc);
    assign opcode  = ir[DATA_W-2 -: 3];
    assign ind_bit = ir[DATA_W-1];
    assign addr    = ir[ADDR_W-1:0];

    // Next-state, sequence counter and next values of the registered strobes.
    always_comb begin
        state_nxt = state;
        sc_nxt    = sc;
        ar_nxt    = 1'b0;
        req_nxt   = mem_req;
        inr_nxt   = 1'b0;
        ovf_nxt   = sc_ovf;
        ir_ld     = 1'b0;
`ifdef INTERRUPT_EN
        int_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = F0;
                    sc_nxt    = '0;
                    ar_nxt    = 1'b1;
                end
            end
            F0: begin
                state_nxt = F1;
                sc_nxt    = SC_W'(1);
                req_nxt   = 1'b1;
            end
            F1: begin
                // SC stalls at T1 until memory answers.
                if (mem_ack) begin
                    ir_ld     = 1'b1;
                    inr_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = DEC;
                    sc_nxt    = SC_W'(2);
                end
            end
            DEC: begin
                state_nxt = EXEC;
                sc_nxt    = SC_W'(3);
            end
            EXEC: begin
                if (hlt) begin
                    state_nxt = HALT;
                    sc_nxt    = '0;
                end else if (sc_clr) begin
                    sc_nxt = '0;
                    if (run) begin
`ifdef INTERRUPT_EN
                        if (ien && irq) begin
                            state_nxt = INTR;
                            int_nxt   = 1'b1;
                        end else begin
                            state_nxt = F0;
                            ar_nxt    = 1'b1;
                        end
`else
                        state_nxt = F0;
                        ar_nxt    = 1'b1;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (sc == SC_MAX) begin
                    // Saturate rather than wrap so T15 stays visible.
                    ovf_nxt = 1'b1;
                end else begin
                    sc_nxt = sc + 1'b1;
                end
            end
            HALT: begin
                // Only a fresh run request restarts the machine.
                if (run && !run_q) begin
                    state_nxt = F0;
                    sc_nxt    = '0;
                    ar_nxt    = 1'b1;
                end
            end
`ifdef INTERRUPT_EN
            INTR: begin
                // RT0..RT2, then resume with a normal fetch.
                if (sc == SC_W'(2)) begin
                    state_nxt = F0;
                    sc_nxt    = '0;
                    ar_nxt    = 1'b1;
                end else begin
                    sc_nxt  = sc + 1'b1;
                    int_nxt = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                sc_nxt    = '0;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // Control state, counter and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sc        <= '0;
            run_q     <= 1'b0;
            ar_ld_pc  <= 1'b0;
            mem_req   <= 1'b0;
            pc_inr    <= 1'b0;
            sc_ovf    <= 1'b0;
`ifdef INTERRUPT_EN
            int_cycle <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sc        <= sc_nxt;
            run_q     <= run;
            ar_ld_pc  <= ar_nxt;
            mem_req   <= req_nxt;
            pc_inr    <= inr_nxt;
            sc_ovf    <= ovf_nxt;
`ifdef INTERRUPT_EN
            int_cycle <= int_nxt;
`endif
        end
    end

    // Instruction register loads only on an ack accepted in F1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_ld) begin
            ir <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ar_ld_pc;
    logic        pc_inr;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic        ind_bit;
    logic [11:0] addr;
    logic [15:0] t;
    logic        sc_clr;
    logic        hlt;
    logic        sc_ovf;
`ifdef INTERRUPT_EN
    logic        ien;
    logic        irq;
    logic        int_cycle;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ar_ld_pc(ar_ld_pc), .pc_inr(pc_inr), .ir(ir),
        .opcode(opcode), .ind_bit(ind_bit), .addr(addr), .t(t),
        .sc_clr(sc_clr), .hlt(hlt),
`ifdef INTERRUPT_EN
        .ien(ien), .irq(irq), .int_cycle(int_cycle),
`endif
        .sc_ovf(sc_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until t shows the given timing slot.
    task automatic wait_t(input logic [15:0] v, input string tag);
        int n = 0;
        while (t !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, t, v);
    endtask

    // Fetch one word with the ack held off for 'delay' F1 cycles; ends at the DEC cycle.
    task automatic do_fetch(input logic [15:0] w, input int delay);
        logic [15:0] e;
        logic [15:0] ir_before;
        wait_t(16'h0002, "reach_f1");
        chk("f1_mem_req", mem_req, 1);
        ir_before = ir;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("stall_t", t, 16'h0002);
            chk("stall_mem_req", mem_req, 1);
            chk("stall_ir", ir, ir_before);
        end
        mem_ack   = 1'b1;
        mem_rdata = w;
        exp_q.push_back(w);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        e = exp_q.pop_front();
        chk("dec_t", t, 16'h0004);
        chk("dec_pc_inr", pc_inr, 1);
        chk("dec_mem_req", mem_req, 0);
        chk("dec_ir", ir, e);
        chk("dec_opcode", opcode, e[14:12]);
        chk("dec_ind_bit", ind_bit, e[15]);
        chk("dec_addr", addr, e[11:0]);
    endtask

    // From DEC, step through EXEC and assert sc_clr at slot k.
    task automatic exec_clr(input int k);
        logic [15:0] et;
        for (int n = 3; n <= k; n++) begin
            @(negedge clk);
            et = 16'h0001 << n;
            chk("exec_t", t, et);
            if (n == k) sc_clr = 1'b1;
        end
        @(negedge clk);
        sc_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] et;
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        sc_clr = 1'b0; hlt = 1'b0;
`ifdef INTERRUPT_EN
        ien = 1'b0; irq = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_t", t, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ar_ld_pc", ar_ld_pc, 0);
        chk("rst_pc_inr", pc_inr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_sc_ovf", sc_ovf, 0);

        // Basic fetch, ack on first F1 cycle.
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);
        chk("t0_t", t, 16'h0001);
        chk("t0_ar_ld_pc", ar_ld_pc, 1);
        do_fetch(16'h7800, 0);
        exec_clr(3);
        chk("refetch_t", t, 16'h0001);
        chk("refetch_ar_ld_pc", ar_ld_pc, 1);

        // Delayed ack, then A123 with sc_clr at T5.
        do_fetch(16'h1234, 4);
        exec_clr(5);
        do_fetch(16'hA123, 0);
        exec_clr(5);
        chk("a123_next_t", t, 16'h0001);
        chk("a123_next_ar", ar_ld_pc, 1);

        // Overflow: no sc_clr, SC saturates at 15.
        do_fetch(16'h3456, 0);
        for (int n = 3; n <= 15; n++) begin
            @(negedge clk);
            et = 16'h0001 << n;
            chk("ovf_walk_t", t, et);
        end
        chk("ovf_not_yet", sc_ovf, 0);
        repeat (2) @(negedge clk);
        chk("ovf_sat_t", t, 16'h8000);
        chk("ovf_flag", sc_ovf, 1);
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0;
        chk("ovf_clr_t", t, 16'h0001);
        chk("ovf_sticky", sc_ovf, 1);

        // hlt and sc_clr together at T3: hlt wins.
        do_fetch(16'h7001, 0);
        @(negedge clk);
        chk("hlt_t3", t, 16'h0008);
        hlt = 1'b1; sc_clr = 1'b1;
        @(negedge clk);
        hlt = 1'b0; sc_clr = 1'b0;
        chk("halt_t", t, 0);
        chk("halt_mem_req", mem_req, 0);
        repeat (3) @(negedge clk);
        chk("halt_stays_t", t, 0);
        chk("halt_no_ar", ar_ld_pc, 0);
        run = 1'b0;
        @(negedge clk);
        chk("halt_run0_t", t, 0);
        run = 1'b1;
        @(negedge clk);
        chk("halt_exit_t", t, 16'h0001);
        chk("halt_exit_ar", ar_ld_pc, 1);

        // run dropped mid-fetch: instruction completes, then IDLE.
        @(negedge clk);
        run = 1'b0;
        do_fetch(16'h5555, 1);
        exec_clr(4);
        chk("stop_idle_t", t, 0);
        chk("stop_idle_ar", ar_ld_pc, 0);
        repeat (2) @(negedge clk);
        chk("stop_stays_t", t, 0);

        // Reset during F1 with mem_req high; late ack ignored.
        run = 1'b1;
        wait_t(16'h0002, "rst_f1_reach");
        chk("rst_f1_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_t", t, 0);
        chk("async_ir", ir, 0);
        chk("async_ovf", sc_ovf, 0);
        @(negedge clk);
        run = 1'b0; rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_ir", ir, 0);
        chk("late_ack_t", t, 0);
        chk("late_ack_pc_inr", pc_inr, 0);

`ifdef INTERRUPT_EN
        run = 1'b1;
        do_fetch(16'h1111, 0);
        @(negedge clk);
        ien = 1'b1; irq = 1'b1; sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0; irq = 1'b0;
        for (int n = 0; n < 3; n++) begin
            et = 16'h0001 << n;
            chk("int_t", t, et);
            chk("int_cycle", int_cycle, 1);
            chk("int_no_req", mem_req, 0);
            @(negedge clk);
        end
        chk("int_done_t", t, 16'h0001);
        chk("int_done_ar", ar_ld_pc, 1);
        chk("int_done_flag", int_cycle, 0);
        do_fetch(16'h2222, 0);
        @(negedge clk);
        ien = 1'b0; irq = 1'b1; sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0; irq = 1'b0;
        chk("noint_t", t, 16'h0001);
        chk("noint_flag", int_cycle, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
